change_dispenser: RTL and testbench

//  Downstream stage of the vending FSM: consumes its per-sale o_soda pulse and 3-bit o_change code.

---
 rtl/change_dispenser.sv | 161 ++++++++++++++++
 tb/tb_change_dispenser.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Sale buffer and actuator sequencer behind the vending FSM.
// Each sale releases one soda, then ejects its nickels one handshake at a time.
module change_dispenser #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_soda,
    input  logic [2:0]                 i_change,
    input  logic                       i_ack,
    output logic                       o_soda_eject,
    output logic                       o_nickel_eject,
    output logic                       o_busy,
    output logic [$clog2(DEPTH+1)-1:0] o_pending,
    output logic                       o_overflow,
    output logic                       o_code_err,
    output logic                       o_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        SODA_REQ,
        SODA_REL,
        COIN_REQ,
        COIN_REL,
        FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    mem_q [DEPTH];

    logic soda_q, soda_d;
    logic nickel_q, nickel_d;
    logic busy_q, busy_d;
    logic overflow_q, overflow_d;
    logic code_err_q, code_err_d;
    logic fault_q, fault_d;

    logic       pop;
    logic       full;
    logic       push_ok;
    logic       bad_code;
    logic [2:0] wr_data;
    logic       timeout;

    always_comb begin
        pop      = (state_q == IDLE) && (count_q != '0);
        full     = (count_q == CW'(DEPTH));
        push_ok  = i_soda && (!full || pop);
        bad_code = (i_change > 3'd4);
        wr_data  = bad_code ? 3'd0 : i_change;

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q | (i_soda & ~push_ok);
        code_err_d = code_err_q | (i_soda & bad_code);
    end

    // An ack on the last allowed cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timeout = (timer_q == TW'(TIMEOUT - 1));
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    cnt_d   = mem_q[rd_ptr_q];
                    state_d = SODA_REQ;
                end
            end
            SODA_REQ: begin
                if (i_ack)        state_d = SODA_REL;
                else if (timeout) state_d = FAULT;
            end
            SODA_REL, COIN_REL: begin
                if (!i_ack)       state_d = (cnt_q != 3'd0) ? COIN_REQ : IDLE;
                else if (timeout) state_d = FAULT;
            end
            COIN_REQ: begin
                if (i_ack) begin
                    state_d = COIN_REL;
                    cnt_d   = cnt_q - 3'd1;
                end else if (timeout) begin
                    state_d = FAULT;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q || state_q == IDLE || state_q == FAULT)
            timer_d = '0;
        else
            timer_d = timer_q + TW'(1);

        soda_d   = (state_d == SODA_REQ);
        nickel_d = (state_d == COIN_REQ);
        fault_d  = (state_d == FAULT);
        busy_d   = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            soda_q     <= 1'b0;
            nickel_q   <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            code_err_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            soda_q     <= soda_d;
            nickel_q   <= nickel_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            code_err_q <= code_err_d;
            fault_q    <= fault_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && push_ok)
            mem_q[wr_ptr_q] <= wr_data;
    end

    assign o_soda_eject   = soda_q;
    assign o_nickel_eject = nickel_q;
    assign o_busy         = busy_q;
    assign o_pending      = count_q;
    assign o_overflow     = overflow_q;
    assign o_code_err     = code_err_q;
    assign o_fault        = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: handshakes, FIFO limits,
// timeout boundary, code errors and reset.
module tb_change_dispenser;

    localparam int DEPTH = 4;
    localparam int TO    = 1000;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_soda;
    logic [2:0] i_change;
    logic       i_ack;
    logic       o_soda_eject;
    logic       o_nickel_eject;
    logic       o_busy;
    logic [2:0] o_pending;
    logic       o_overflow;
    logic       o_code_err;
    logic       o_fault;

    int checks   = 0;
    int failures = 0;

    change_dispenser #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_soda         (i_soda),
        .i_change       (i_change),
        .i_ack          (i_ack),
        .o_soda_eject   (o_soda_eject),
        .o_nickel_eject (o_nickel_eject),
        .o_busy         (o_busy),
        .o_pending      (o_pending),
        .o_overflow     (o_overflow),
        .o_code_err     (o_code_err),
        .o_fault        (o_fault)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        i_rst = 1'b1;
        i_soda = 1'b0;
        i_change = 3'd0;
        i_ack = 1'b0;
        step();
        step();
        i_rst = 1'b0;
    endtask

    task automatic sale(input logic [2:0] code);
        i_soda = 1'b1;
        i_change = code;
        step();
        i_soda = 1'b0;
    endtask

    // Ack follows the eject lines two samples late; pulses counted on fall.
    task automatic respond(output int ns, output int nn,
                           output bit done, output bit both);
        logic d1, d2, ps, pn;
        d1 = 1'b0;
        d2 = 1'b0;
        ps = o_soda_eject;
        pn = o_nickel_eject;
        ns = 0;
        nn = 0;
        done = 1'b0;
        both = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            i_ack = d2;
            step();
            if (o_soda_eject && o_nickel_eject) both = 1'b1;
            if (ps && !o_soda_eject) ns++;
            if (pn && !o_nickel_eject) nn++;
            ps = o_soda_eject;
            pn = o_nickel_eject;
            d2 = d1;
            d1 = o_soda_eject | o_nickel_eject;
            if (!o_busy && !ps && !pn && !i_ack) done = 1'b1;
        end
        i_ack = 1'b0;
    endtask

    initial begin
        int  ns, nn;
        bit  done, both;

        // reset state
        reset_dut();
        chk("rst_soda", o_soda_eject, 0);
        chk("rst_nickel", o_nickel_eject, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_pending", o_pending, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_cerr", o_code_err, 0);
        chk("rst_fault", o_fault, 0);

        // 1: two nickels
        sale(3'd2);
        chk("t1_pend1", o_pending, 1);
        chk("t1_busy", o_busy, 1);
        chk("t1_soda_t", o_soda_eject, 0);
        step();
        step();
        chk("t1_soda_t2", o_soda_eject, 1);
        chk("t1_pend0", o_pending, 0);
        respond(ns, nn, done, both);
        chk("t1_done", done, 1);
        chk("t1_sodas", ns, 1);
        chk("t1_nickels", nn, 2);
        chk("t1_both", both, 0);
        chk("t1_busy_end", o_busy, 0);

        // 2: no change
        sale(3'd0);
        chk("t2_pend1", o_pending, 1);
        respond(ns, nn, done, both);
        chk("t2_done", done, 1);
        chk("t2_sodas", ns, 1);
        chk("t2_nickels", nn, 0);
        chk("t2_pend0", o_pending, 0);

        // 4a: ack on the last allowed cycle wins over timeout
        sale(3'd0);
        step();
        for (int k = 0; k < TO - 1; k++) step();
        chk("t4a_nofault", o_fault, 0);
        chk("t4a_soda", o_soda_eject, 1);
        i_ack = 1'b1;
        step();
        chk("t4a_fault", o_fault, 0);
        chk("t4a_rel", o_soda_eject, 0);
        i_ack = 1'b0;
        step();
        chk("t4a_idle", o_busy, 0);

        // 4b: timeout in SODA_REQ
        sale(3'd0);
        step();
        for (int k = 0; k < TO - 1; k++) step();
        chk("t4b_pre_fault", o_fault, 0);
        chk("t4b_pre_soda", o_soda_eject, 1);
        step();
        chk("t4b_fault", o_fault, 1);
        chk("t4b_soda", o_soda_eject, 0);
        chk("t4b_nickel", o_nickel_eject, 0);
        i_soda = 1'b1;
        i_change = 3'd1;
        step();
        chk("t4b_pend1", o_pending, 1);
        step();
        i_soda = 1'b0;
        chk("t4b_pend2", o_pending, 2);
        step();
        chk("t4b_pend_hold", o_pending, 2);
        chk("t4b_fault_hold", o_fault, 1);

        // 3: overflow with ack held low
        reset_dut();
        i_soda = 1'b1;
        i_change = 3'd1;
        for (int k = 0; k < 4; k++) step();
        chk("t3_pend3", o_pending, 3);
        chk("t3_ovf0", o_overflow, 0);
        step();
        chk("t3_pend4", o_pending, 4);
        step();
        i_soda = 1'b0;
        chk("t3_pend4b", o_pending, 4);
        chk("t3_ovf1", o_overflow, 1);
        step();
        chk("t3_ovf_sticky", o_overflow, 1);

        // 5a: bad change code stores soda-only sale
        reset_dut();
        sale(3'd6);
        chk("t5_cerr", o_code_err, 1);
        respond(ns, nn, done, both);
        chk("t5_done", done, 1);
        chk("t5_sodas", ns, 1);
        chk("t5_nickels", nn, 0);

        // 5b: reset in COIN_REQ
        sale(3'd2);
        step();
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        step();
        chk("t5_coin_req", o_nickel_eject, 1);
        chk("t5_soda_off", o_soda_eject, 0);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("t5r_soda", o_soda_eject, 0);
        chk("t5r_nickel", o_nickel_eject, 0);
        chk("t5r_busy", o_busy, 0);
        chk("t5r_pending", o_pending, 0);
        chk("t5r_ovf", o_overflow, 0);
        chk("t5r_cerr", o_code_err, 0);
        chk("t5r_fault", o_fault, 0);

        // 6: push into full FIFO on the cycle IDLE pops
        sale(3'd0);
        step();
        i_soda = 1'b1;
        for (int k = 0; k < 4; k++) step();
        i_soda = 1'b0;
        chk("t6_full", o_pending, 4);
        chk("t6_ovf_pre", o_overflow, 0);
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        step();
        chk("t6_idle_full", o_pending, 4);
        chk("t6_idle_soda", o_soda_eject, 0);
        i_soda = 1'b1;
        step();
        i_soda = 1'b0;
        chk("t6_pend", o_pending, 4);
        chk("t6_ovf", o_overflow, 0);
        chk("t6_soda", o_soda_eject, 1);
        chk("t6_busy", o_busy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
